// File: rtl/chunked_add_sequencer_pkg.sv
// rtl/chunked_add_sequencer_pkg.sv - shared state encoding and sizing helpers for the chunked adder
package chunked_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int CHUNK_DEFAULT = 4;

  // Width of the chunk index; kept at least one bit so a single-chunk build still has a counter
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/carry_skip_add4.sv
// rtl/carry_skip_add4.sv - 4-bit carry-skip adder slice
module carry_skip_add4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p    = a_i ^ b_i;
  assign g    = a_i & b_i;
  assign c[0] = cin_i;

  for (genvar i = 0; i < 4; i++) begin : g_ripple
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign sum_o  = p ^ c[3:0];
  // When every bit propagates the carry-in bypasses the ripple chain
  assign cout_o = (&p) ? cin_i : c[4];

endmodule

// File: rtl/chunked_add_top.sv
// rtl/chunked_add_top.sv - sequencer paired with the 4-bit carry-skip slice
module chunked_add_top #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] add_sum;
  logic       add_cin;
  logic       add_cout;

  chunked_add_sequencer #(.WIDTH(WIDTH), .CHUNK(4)) u_seq (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  carry_skip_add4 u_slice (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

endmodule

// File: rtl/chunked_add_sequencer.sv
// rtl/chunked_add_sequencer.sv - feeds a WIDTH-bit add/sub through an external CHUNK-bit slice, LSB chunk first
import chunked_add_sequencer_pkg::*;

module chunked_add_sequencer #(
  parameter int WIDTH = 16,
  parameter int CHUNK = CHUNK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic [CHUNK-1:0] add_a,
  output logic [CHUNK-1:0] add_b,
  output logic             add_cin,
  input  logic [CHUNK-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             a_msb_q;
  logic             beff_msb_q;
  logic             c_out_q;
  logic             ovf_q;
  logic [WIDTH-1:0] b_eff_d;

  assign b_eff_d = sub ? ~b : b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_msb_q    <= 1'b0;
      beff_msb_q <= 1'b0;
      c_out_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= RUN;
            a_q        <= a;
            b_q        <= b_eff_d;
            carry_q    <= sub ? 1'b1 : c_in;
            idx_q      <= '0;
            a_msb_q    <= a[WIDTH-1];
            beff_msb_q <= b_eff_d[WIDTH-1];
          end
        end
        RUN: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= add_sum;
          carry_q <= add_cout;
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          idx_q   <= idx_q + 1'b1;
          // Overflow is decided from the top chunk's sum MSB against the latched operand signs
          if (idx_q == IDX_LAST) begin
            state_q <= DONE;
            c_out_q <= add_cout;
            ovf_q   <= (a_msb_q == beff_msb_q) && (add_sum[CHUNK-1] != a_msb_q);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign add_a     = (state_q == RUN) ? a_q[CHUNK-1:0] : '0;
  assign add_b     = (state_q == RUN) ? b_q[CHUNK-1:0] : '0;
  assign add_cin   = (state_q == RUN) ? carry_q : 1'b0;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// tb/tb_chunked_add_sequencer.sv - directed vector bench for chunked_add_sequencer
module tb_chunked_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        sub;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
    logic [3:0]  cin_seq;
  } vec_t;

  vec_t vecs[8];
  vec_t v_one;

  chunked_add_sequencer #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  // Behavioural stand-in for the external slice
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    logic [15:0] sa;
    logic [15:0] sb;
    logic [15:0] beff;
    logic [3:0]  sc;
    beff = v.sub ? ~v.b : v.b;
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    a = v.a; b = v.b; c_in = v.c_in; sub = v.sub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 16'hdead; b = 16'hbeef; c_in = 1'b0; sub = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sa[k*4 +: 4] = add_a;
      sb[k*4 +: 4] = add_b;
      sc[k]        = add_cin;
      if (k == 3) check({tag, " early out_valid"}, 32'(out_valid), 32'd0);
    end
    check({tag, " add_a seq"}, 32'(sa), 32'(v.a));
    check({tag, " add_b seq"}, 32'(sb), 32'(beff));
    check({tag, " add_cin seq"}, 32'(sc), 32'(v.cin_seq));
    @(negedge clk);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    check({tag, " sum"}, 32'(sum), 32'(v.sum));
    check({tag, " c_out"}, 32'(c_out), 32'(v.c_out));
    check({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " out_valid after pop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    //          a         b         cin   sub   sum       cout  ovf   cin_seq
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0001};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0001};
    vecs[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0111};
    vecs[6] = '{16'h0007, 16'h0007, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
    v_one   = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 4'b0000};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset c_out", 32'(c_out), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset add_a", 32'(add_a), 32'd0);
    check("reset add_cin", 32'(add_cin), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
      pop($sformatf("vec%0d", i));
    end

    // Backpressure: DONE is held, a stray request is dropped
    run_op(vecs[0], "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin in_valid = 1'b1; a = 16'hAAAA; b = 16'h1111; end
      if (i == 2) in_valid = 1'b0;
      check($sformatf("bp hold valid %0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp hold sum %0d", i), 32'(sum), 32'h5555);
      check($sformatf("bp in_ready %0d", i), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    pop("bp");
    check("bp in_ready after pop", 32'(in_ready), 32'd1);
    run_op(vecs[3], "bp next");
    pop("bp next");

    // rst and in_valid together: nothing accepted
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 16'h0001; b = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst+valid in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rst+valid idle add_a %0d", i), 32'(add_a), 32'd0);
      check($sformatf("rst+valid no result %0d", i), 32'(out_valid), 32'd0);
    end

    // Reset during RUN cycle 2 abandons the operation
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrun in_ready", 32'(in_ready), 32'd1);
    check("midrun sum cleared", 32'(sum), 32'd0);
    check("midrun add_a idle", 32'(add_a), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("midrun no result %0d", i), 32'(out_valid), 32'd0);
    end
    run_op(v_one, "after midrun");
    pop("after midrun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chunked_add_sequencer.md
# chunked_add_sequencer

Multi-cycle operand sequencer that sits directly upstream of a 4-bit adder slice, such as the 4-bit carry-skip block. It accepts a WIDTH-bit add/subtract request over a valid/ready handshake. It then feeds the external slice one CHUNK-bit slice per cycle, LSB chunk first, threading the carry between cycles and collecting the partial sums. The assembled WIDTH-bit result, carry-out and signed overflow are returned over a second valid/ready handshake.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of CHUNK.
- CHUNK, 4: width of the external adder slice.
- N (derived), WIDTH/CHUNK: number of chunk cycles.

- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at a clk edge.
- a, b  in  WIDTH  operands, unsigned or two's complement.
- c_in  in  1  carry-in; used only when sub=0.
- sub  in  1  1 = compute a + ~b + 1; c_in is ignored.
- add_a, add_b  out  CHUNK  current chunk driven to the slice; add_b is already inverted when sub=1.
- add_cin  out  1  carry into the current chunk.
- add_sum  in  CHUNK  slice sum; combinational, stable within the cycle.
- add_cout  in  1  slice carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready at a clk edge.
- sum  out  WIDTH  result.
- c_out  out  1  final carry.
- ovf  out  1  signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) && !rst. out_valid = (state==DONE).
- IDLE→RUN on accept. At the accept edge the block latches:
  - a_reg ← a;
  - b_reg ← sub ? ~b : b;
  - carry ← sub ? 1 : c_in;
  - idx ← 0;
  - msb flags: a_msb, beff_msb.
- RUN, cycle k (k = 0..N-1):
  - add_a = a_reg[CHUNK-1:0], add_b = b_reg[CHUNK-1:0], add_cin = carry.
  - At the edge: sum[k*CHUNK +: CHUNK] ← add_sum; carry ← add_cout; a_reg and b_reg shift right by CHUNK; idx ← idx+1.
  - When idx==N-1, the edge moves to DONE and sets c_out ← add_cout and ovf ← (a_msb==beff_msb) && (add_sum[CHUNK-1]!=a_msb).
- DONE: sum, c_out and ovf are held stable. DONE→IDLE on out_ready.
- Outside RUN, add_a, add_b and add_cin are driven 0.
- Arithmetic is modulo 2^WIDTH. c_out is the raw carry: for sub, c_out=1 means no borrow.
- Only one operation is in flight. in_valid asserted in RUN or DONE is ignored and not queued.

## Timing
- Reset values (at the rst edge): state=IDLE; out_valid, sum, c_out, ovf, carry and idx = 0; add_* = 0. in_ready is 0 while rst is high and 1 in the first cycle after.
- Latency: accept at edge E0 gives out_valid high after edge E0+N (N=4 at default).
- Minimum op-to-op spacing is N+2 cycles (IDLE, N×RUN, DONE with out_ready already high).
- out_ready held low keeps DONE indefinitely with outputs frozen.
- Reset mid-RUN or in DONE: the operation is abandoned at that edge, no out_valid is produced, and all values return to reset state.
- rst and in_valid asserted in the same cycle: rst wins and nothing is accepted.
- The idx counter never wraps in RUN; the exit is decoded at N-1.
- The external slice path from add_* to add_sum/add_cout must settle within one clk period.

## Structure
- Shared package:
  - state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - default CHUNK=4;
  - function for the idx width, $clog2(N).
- No internal sub-module: the FSM, shift registers and result assembly are one module.
- A separate wrapper, chunked_add_top, pairs this block with a 4-bit adder slice (the carry-skip 4-bit block) for system use and benches.

## Test plan
- Reset: rst high 2 cycles → out_valid=0, sum=0, c_out=0, ovf=0; in_ready=1 in the first cycle after rst drops.
- Plain add: a=0x1234, b=0x4321, c_in=0, sub=0 → add_a sequence 4,3,2,1 over the RUN cycles; 4 cycles after accept, out_valid=1, sum=0x5555, c_out=0, ovf=0.
- Full ripple: a=0xFFFF, b=0x0001, c_in=0 → add_cin sequence 0,1,1,1; sum=0x0000, c_out=1, ovf=0.
- Subtract and overflow:
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, c_out=0, ovf=0.
  - a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, c_out=0, ovf=1.
- Backpressure: out_ready low for 5 cycles after out_valid → sum held; in_ready=0; a pulse on in_valid is ignored. Raise out_ready → IDLE next cycle, and a new request is accepted.
- Reset mid-operation: rst during RUN cycle 2 → out_valid never asserts and state is IDLE. A following 0x0001+0x0001 request → sum=0x0002.
